int_mac_accum: RTL and testbench

Sequential multiply-accumulate back end that consumes the 32-bit products from the extended-ALU 16x16 integer multiplier. It sums a programmed number of products, each signed or unsigned, into a wide internal accumulator, which is how neural-net dot products are formed. It then returns a 32-bit saturated result over a valid/ready handshake. It sits between the multiplier output and the register-file/writeback path of the extended ALU.

---
 rtl/int_mac_accum.sv | 138 +++++++++++++
 tb/tb_int_mac_accum.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/int_mac_accum.sv
// int_mac_accum: sequential multiply-accumulate back end.
// Sums a programmed number of 32-bit products into a wide accumulator.
// The 32-bit result is clamped to the signed or unsigned range chosen at start.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Valid never depends on ready, and ready never depends on valid. A
// producer holds its payload stable while valid is high and ready is low.
// prod_rdy is a function of state only. res_vld stays high with res/ovfl frozen
// until res_rdy is seen.
module int_mac_accum #(
   parameter int ACC_W = 48  // keep >= 48 so 65535 full-scale products cannot wrap
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] len,
   input  logic        sign,
   input  logic        prod_vld,
   input  logic [31:0] prod,
   output logic        prod_rdy,
   output logic        res_vld,
   output logic [31:0] res,
   input  logic        res_rdy,
   output logic        ovfl,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [ACC_W-1:0]   acc;
   logic [15:0]        cnt;
   logic               sign_q;
   logic               ovfl_q;

   logic [ACC_W-1:0]   prod_ext;
   logic [ACC_W-1:0]   sum;
   logic [ACC_W-32:0]  sum_hi;
   logic [31:0]        sat_res;
   logic               sat_ovf;
   logic               accept;

   assign accept    = prod_vld && prod_rdy;
   assign ovfl      = ovfl_q && res_vld;
   assign state_dbg = state;

   // Extend the incoming product, add it to the running sum, and clamp the result to 32 bits.
   always_comb begin
      prod_ext = sign_q ? {{(ACC_W-32){prod[31]}}, prod}
                        : {{(ACC_W-32){1'b0}}, prod};
      sum      = acc + prod_ext;
      sum_hi   = sum[ACC_W-1:31];
      sat_res  = sum[31:0];
      sat_ovf  = 1'b0;
      if (sign_q) begin
         // In range only when bits 31 and up are a pure sign extension.
         if (!((sum_hi == '0) || (sum_hi == '1))) begin
            sat_ovf = 1'b1;
            sat_res = sum[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         end
      end else begin
         // Zero-extended products only grow the sum, so only the top needs clamping.
         if (|sum[ACC_W-1:32]) begin
            sat_ovf = 1'b1;
            sat_res = 32'hFFFF_FFFF;
         end
      end
   end

   // Compute the next state and the state-decoded handshake and status outputs.
   always_comb begin
      state_nxt = state;
      prod_rdy  = 1'b0;
      res_vld   = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (len != 16'd0) ? ACCUM : DONE;
         end
         ACCUM: begin
            prod_rdy = 1'b1;
            busy     = 1'b1;
            if (prod_vld && cnt == 16'd1) state_nxt = DONE;
         end
         DONE: begin
            res_vld = 1'b1;
            busy    = 1'b1;
            if (res_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Register the state, accumulator and count, and capture the clamped result when the last product is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         cnt    <= '0;
         sign_q <= 1'b0;
         res    <= '0;
         ovfl_q <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  if (len != 16'd0) begin
                     acc    <= '0;
                     cnt    <= len;
                     sign_q <= sign;
                  end else begin
                     res    <= '0;
                     ovfl_q <= 1'b0;
                  end
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc <= sum;
                  cnt <= cnt - 16'd1;
                  if (cnt == 16'd1) begin
                     res    <= sat_res;
                     ovfl_q <= sat_ovf;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_int_mac_accum.sv
// Self-checking bench for int_mac_accum.
// It runs directed cases for the basic, bubble, saturation, len=0 and reset
// scenarios, followed by randomized runs. Expected results come from
// wide-integer arithmetic followed by a clamp.
module tb_int_mac_accum;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] len;
   logic        sign;
   logic        prod_vld;
   logic [31:0] prod;
   logic        prod_rdy;
   logic        res_vld;
   logic [31:0] res;
   logic        res_rdy;
   logic        ovfl;
   logic        busy;
   logic [1:0]  state_dbg;

   int_mac_accum #(.ACC_W(48)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .sign(sign),
      .prod_vld(prod_vld), .prod(prod), .prod_rdy(prod_rdy),
      .res_vld(res_vld), .res(res), .res_rdy(res_rdy), .ovfl(ovfl),
      .busy(busy), .state_dbg(state_dbg)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [32:0] exp_q[$];          // {ovfl, res}
   logic [31:0] prods[16];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: exact integer sum, then clamp to the 32-bit range.
   task automatic model_push(input int n, input bit sg);
      longint sum;
      logic [31:0] r;
      logic        o;
      sum = 0;
      for (int i = 0; i < n; i++)
         sum += sg ? longint'($signed(prods[i])) : longint'({32'd0, prods[i]});
      o = 1'b0;
      r = sum[31:0];
      if (sg) begin
         if (sum > 64'sd2147483647)       begin r = 32'h7FFF_FFFF; o = 1'b1; end
         else if (sum < -64'sd2147483648) begin r = 32'h8000_0000; o = 1'b1; end
      end else if (sum > 64'sd4294967295) begin
         r = 32'hFFFF_FFFF; o = 1'b1;
      end
      exp_q.push_back({o, r});
   endtask

   // ---------------- monitor: pop on each completed result handshake ----------------
   always @(negedge clk) begin
      if (!rst && res_vld && res_rdy) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL result_unexpected: got %0h expected none", {ovfl, res});
         end else begin
            check("result", {31'd0, ovfl, res}, {31'd0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic feed(input logic [31:0] p);
      int t;
      prod_vld = 1'b1;
      prod     = p;
      t        = 0;
      while (!prod_rdy && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 50) check("accept_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      prod_vld = 1'b0;
      prod     = $urandom;
   endtask

   // Runs one complete operation using prods[0..n-1]. It inserts bub idle cycles
   // between products, and holds res_rdy low for rdy_wait cycles with start
   // asserted while the result is pending.
   task automatic run_op(input int n, input bit sg, input int bub, input int rdy_wait);
      logic [31:0] held;
      model_push(n, sg);
      start = 1'b1;
      len   = 16'(n);
      sign  = sg;
      @(posedge clk); #1;
      start = 1'b0;
      len   = 16'($urandom);         // must not disturb the running operation
      sign  = 1'($urandom);
      for (int i = 0; i < n; i++) begin
         feed(prods[i]);
         if (i < n - 1) begin
            for (int b = 0; b < bub; b++) begin
               if (b == 0) check("prod_rdy_bubble", {63'd0, prod_rdy}, 64'd1);
               @(posedge clk); #1;
            end
         end
      end
      check("res_vld_latency", {63'd0, res_vld}, 64'd1);
      check("prod_rdy_done", {63'd0, prod_rdy}, 64'd0);
      held  = res;
      start = 1'b1;                 // ignored throughout DONE and on the handoff
      len   = 16'd5;
      for (int w = 0; w < rdy_wait; w++) begin
         @(posedge clk); #1;
         if (w == rdy_wait - 1) begin
            check("hold_vld", {63'd0, res_vld}, 64'd1);
            check("hold_res", {32'd0, res}, {32'd0, held});
         end
      end
      res_rdy = 1'b1;
      @(posedge clk); #1;
      res_rdy = 1'b0;
      start   = 1'b0;
      check("handoff_idle", {62'd0, state_dbg}, 64'd0);
      check("res_after_handoff", {32'd0, res}, {32'd0, held});
   endtask

   // ---------------- main stimulus ----------------
   initial begin
      logic [15:0] a, b;
      int n;
      bit sg;
      rst = 1'b1; start = 1'b0; len = '0; sign = 1'b0;
      prod_vld = 1'b0; prod = '0; res_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_outputs", {28'd0, prod_rdy, res_vld, ovfl, busy, state_dbg, res}, 64'd0);

      // unsigned basic, back-to-back
      prods[0] = 32'd6; prods[1] = 32'd20; prods[2] = 32'hFFFF_0001;
      run_op(3, 1'b0, 0, 0);
      // signed with 2-cycle bubbles
      prods[0] = 32'hFFFF_FFFF; prods[1] = 32'd5; prods[2] = 32'hFFFF_FFF6; prods[3] = 32'd3;
      run_op(4, 1'b1, 2, 1);
      // saturation cases
      prods[0] = 32'h7FFF_FFFF; prods[1] = 32'd1;
      run_op(2, 1'b1, 0, 0);
      prods[0] = 32'hFFFF_FFFF; prods[1] = 32'd2;
      run_op(2, 1'b0, 1, 0);
      prods[0] = 32'h8000_0000; prods[1] = 32'hFFFF_FFFF;
      run_op(2, 1'b1, 0, 2);
      // len = 0 with backpressure and start held in DONE
      run_op(0, 1'b0, 0, 5);

      // reset in the middle of an operation
      start = 1'b1; len = 16'd10; sign = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) feed(32'd100 + 32'(i));
      prod_vld = 1'b1; prod = 32'd9;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; prod_vld = 1'b0;
      check("midop_reset_outputs", {28'd0, prod_rdy, res_vld, ovfl, busy, state_dbg, res}, 64'd0);
      prods[0] = 32'd7;
      run_op(1, 1'b0, 0, 0);

      // randomized runs: 16x16 products, with occasional raw 32-bit values to reach saturation
      for (int r = 0; r < 100; r++) begin
         n  = $urandom_range(16, 1);
         sg = 1'($urandom);
         for (int i = 0; i < n; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(3, 0) == 0) prods[i] = $urandom;
            else if (sg) prods[i] = 32'(int'($signed(a)) * int'($signed(b)));
            else         prods[i] = 32'(longint'({16'd0, a}) * longint'({16'd0, b}));
         end
         run_op(n, sg, $urandom_range(2, 0), $urandom_range(3, 0));
      end

      repeat (2) @(posedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
